// File: rtl/cpu_beat_gen.sv
//------------------------------------------------------------------------------
// cpu_beat_gen : four-beat (T1..T4) timing-pulse generator for the multicycle CPU
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_beat_gen #(
   parameter int DIV   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic             halt,
   output logic [3:0]       phase,
   output logic             beat_en,
   output logic             instr_done,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam int              PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
   localparam logic [3:0]      PH_T1   = 4'b0001;
   localparam logic [3:0]      PH_OFF  = 4'b0000;

   state_t             state_q, state_d;
   logic [3:0]         phase_q, phase_d;
   logic               beat_en_q, beat_en_d;
   logic               done_q, done_d;
   logic               running_q, running_d;
   logic               halted_q, halted_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic               pend_q, pend_d;
   logic               w_tick;

   assign w_tick = (pre_q == PRE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         phase_q   <= PH_OFF;
         beat_en_q <= 1'b0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         count_q   <= '0;
         pre_q     <= '0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         beat_en_q <= beat_en_d;
         done_q    <= done_d;
         running_q <= running_d;
         halted_q  <= halted_d;
         count_q   <= count_d;
         pre_q     <= pre_d;
         pend_q    <= pend_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      beat_en_d = 1'b0;
      done_d    = 1'b0;
      count_d   = count_q;
      pre_d     = pre_q;
      pend_d    = pend_q;

      // halt wins over everything, including a coincident instruction boundary
      if (halt || state_q == S_HALTED) begin
         state_d = S_HALTED;
         phase_d = PH_OFF;
         pre_d   = '0;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start || step) begin
                  state_d   = start ? S_RUN : S_STEP;
                  phase_d   = PH_T1;
                  beat_en_d = 1'b1;
                  pre_d     = '0;
               end
            end
            S_RUN, S_STEP: begin
               if (state_q == S_RUN && stop) begin
                  pend_d = 1'b1;
               end
               if (w_tick) begin
                  pre_d = '0;
                  if (phase_q[3]) begin
                     done_d  = 1'b1;
                     count_d = count_q + CNT_W'(1);
                     // pend_d already folds in a stop seen during the final tick cycle
                     if (state_q == S_STEP || pend_d) begin
                        state_d = S_IDLE;
                        phase_d = PH_OFF;
                        pend_d  = 1'b0;
                     end else begin
                        phase_d   = PH_T1;
                        beat_en_d = 1'b1;
                     end
                  end else begin
                     phase_d   = {phase_q[2:0], 1'b0};
                     beat_en_d = 1'b1;
                  end
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               phase_d = PH_OFF;
            end
         endcase
      end

      running_d = (state_d == S_RUN) || (state_d == S_STEP);
      halted_d  = (state_d == S_HALTED);
   end

   assign phase       = phase_q;
   assign beat_en     = beat_en_q;
   assign instr_done  = done_q;
   assign running     = running_q;
   assign halted      = halted_q;
   assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_beat_gen.sv
//------------------------------------------------------------------------------
// tb_cpu_beat_gen : table-driven and directed checks of cpu_beat_gen
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_beat_gen;

   logic clk, rst, start, stop, step, halt;

   logic [3:0]  d2_ph, d3_ph, d1_ph;
   logic        d2_be, d3_be, d1_be;
   logic        d2_dn, d3_dn, d1_dn;
   logic        d2_rn, d3_rn, d1_rn;
   logic        d2_ht, d3_ht, d1_ht;
   logic [15:0] d2_cnt, d3_cnt;
   logic [3:0]  d1_cnt;

   cpu_beat_gen #(.DIV(2), .CNT_W(16)) u_d2 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .halt(halt),
      .phase(d2_ph), .beat_en(d2_be), .instr_done(d2_dn), .running(d2_rn),
      .halted(d2_ht), .instr_count(d2_cnt));

   cpu_beat_gen #(.DIV(3), .CNT_W(16)) u_d3 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .halt(halt),
      .phase(d3_ph), .beat_en(d3_be), .instr_done(d3_dn), .running(d3_rn),
      .halted(d3_ht), .instr_count(d3_cnt));

   cpu_beat_gen #(.DIV(1), .CNT_W(4)) u_d1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .halt(halt),
      .phase(d1_ph), .beat_en(d1_be), .instr_done(d1_dn), .running(d1_rn),
      .halted(d1_ht), .instr_count(d1_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st, sp, se, hl;
      logic [3:0]  ph;
      logic        be, dn, rn, ht;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[26];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [23:0] pk(logic [3:0] ph, logic be, logic dn, logic rn,
                                      logic ht, logic [15:0] cnt);
      return {ph, be, dn, rn, ht, cnt};
   endfunction

   function automatic vec_t mk(logic st, logic sp, logic se, logic hl, logic [3:0] ph,
                               logic be, logic dn, logic rn, logic ht, logic [15:0] cnt);
      vec_t v;
      v.st = st; v.sp = sp; v.se = se; v.hl = hl;
      v.ph = ph; v.be = be; v.dn = dn; v.rn = rn; v.ht = ht; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [23:0] g2();
      return {d2_ph, d2_be, d2_dn, d2_rn, d2_ht, d2_cnt};
   endfunction
   function automatic logic [23:0] g3();
      return {d3_ph, d3_be, d3_dn, d3_rn, d3_ht, d3_cnt};
   endfunction
   function automatic logic [23:0] g1();
      return {d1_ph, d1_be, d1_dn, d1_rn, d1_ht, 12'h000, d1_cnt};
   endfunction

   // word layout: phase[23:20] beat_en done running halted count[15:0]
   task automatic chk(input string name, input int idx, input logic [23:0] got,
                      input logic [23:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic ctl(input logic st, input logic sp, input logic se, input logic hl);
      start = st; stop = sp; step = se; halt = hl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ctl(0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] eph;
      ctl(0, 0, 0, 0);
      rst = 1'b0;
      #2;

      // reset then idle
      do_reset();
      chk("rst_d2", 0, g2(), pk(0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_d2", c, g2(), pk(0, 0, 0, 0, 0, 0));
      end

      // free run, DIV=2: 24 cycles after start gives count 3
      for (int c = 0; c <= 24; c++) begin
         ctl(c == 0, 0, 0, 0);
         tick();
         eph = 4'(1 << ((c / 2) % 4));
         chk("free_d2", c, g2(), pk(eph, (c % 2) == 0, (c >= 8) && (c % 8 == 0), 1, 0,
                                    16'(c / 8)));
      end
      do_reset();

      // table: run, stop at boundary, step with ignored inputs, halt in T3
      tbl[0]  = mk(1, 0, 0, 0, 4'b0001, 1, 0, 1, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 4'b0010, 1, 0, 1, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 4'b0100, 1, 0, 1, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 4'b0100, 0, 0, 1, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 4'b1000, 1, 0, 1, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 4'b1000, 0, 0, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 4'b0001, 1, 1, 1, 0, 1);
      tbl[9]  = mk(0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 1);
      tbl[10] = mk(0, 1, 0, 0, 4'b0010, 1, 0, 1, 0, 1);
      tbl[11] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 4'b0100, 1, 0, 1, 0, 1);
      tbl[13] = mk(0, 0, 0, 0, 4'b0100, 0, 0, 1, 0, 1);
      tbl[14] = mk(0, 0, 0, 0, 4'b1000, 1, 0, 1, 0, 1);
      tbl[15] = mk(0, 0, 0, 0, 4'b1000, 0, 0, 1, 0, 1);
      tbl[16] = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0, 2);
      tbl[17] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2);
      tbl[18] = mk(0, 0, 1, 0, 4'b0001, 1, 0, 1, 0, 2);
      tbl[19] = mk(0, 0, 1, 0, 4'b0001, 0, 0, 1, 0, 2);
      tbl[20] = mk(1, 0, 0, 0, 4'b0010, 1, 0, 1, 0, 2);
      tbl[21] = mk(0, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 2);
      tbl[22] = mk(0, 0, 0, 0, 4'b0100, 1, 0, 1, 0, 2);
      tbl[23] = mk(0, 0, 0, 1, 4'b0000, 0, 0, 0, 1, 2);
      tbl[24] = mk(1, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 2);
      tbl[25] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 2);
      for (int i = 0; i < 26; i++) begin
         ctl(tbl[i].st, tbl[i].sp, tbl[i].se, tbl[i].hl);
         tick();
         chk("tbl_d2", i, g2(), pk(tbl[i].ph, tbl[i].be, tbl[i].dn, tbl[i].rn,
                                   tbl[i].ht, tbl[i].cnt));
      end
      do_reset();
      chk("unhalt_d2", 0, g2(), pk(0, 0, 0, 0, 0, 0));

      // stop during T2 with DIV=3, then resume
      for (int c = 0; c < 12; c++) begin
         ctl(c == 0, c == 4, 0, 0);
         tick();
         eph = 4'(1 << (c / 3));
         chk("stop_d3", c, g3(), pk(eph, (c % 3) == 0, 0, 1, 0, 0));
      end
      ctl(0, 0, 0, 0);
      tick();
      chk("stop_bnd_d3", 0, g3(), pk(0, 0, 1, 0, 0, 1));
      tick();
      chk("stop_idle_d3", 0, g3(), pk(0, 0, 0, 0, 0, 1));
      ctl(1, 0, 0, 0);
      tick();
      chk("resume_d3", 0, g3(), pk(4'b0001, 1, 0, 1, 0, 1));
      do_reset();

      // single step, DIV=1
      for (int c = 0; c < 5; c++) begin
         ctl(0, 0, c == 0, 0);
         tick();
         if (c < 4) chk("step_d1", c, g1(), pk(4'(1 << c), 1, 0, 1, 0, 0));
         else       chk("step_d1", c, g1(), pk(0, 0, 1, 0, 0, 1));
      end
      // step held high re-steps every 5 cycles
      for (int c = 0; c < 10; c++) begin
         ctl(0, 0, 1, 0);
         tick();
         if (c % 5 < 4) chk("stephold_d1", c, g1(), pk(4'(1 << (c % 5)), 1, 0, 1, 0,
                                                      16'(1 + c / 5)));
         else           chk("stephold_d1", c, g1(), pk(0, 0, 1, 0, 0, 16'(2 + c / 5)));
      end
      do_reset();

      // 16 instructions with a 4-bit counter: 15 -> 0
      for (int c = 0; c <= 64; c++) begin
         ctl(c == 0, 0, 0, 0);
         tick();
         chk("wrap_d1", c, g1(), pk(4'(1 << (c % 4)), 1, (c >= 4) && (c % 4 == 0), 1, 0,
                                    16'((c / 4) % 16)));
      end
      do_reset();

      // start+step together selects RUN; halt on the T4 tick cancels the boundary
      for (int c = 0; c <= 8; c++) begin
         ctl(c == 0, 0, c == 0, c == 8);
         tick();
         if (c < 8) chk("runstep_d1", c, g1(), pk(4'(1 << (c % 4)), 1, c == 4, 1, 0,
                                                  16'(c / 4)));
         else       chk("haltbnd_d1", c, g1(), pk(0, 0, 0, 0, 1, 1));
      end
      do_reset();

      // asynchronous reset during T2
      for (int c = 0; c < 3; c++) begin
         ctl(c == 0, 0, 0, 0);
         tick();
      end
      chk("pre_arst_d2", 0, g2(), pk(4'b0010, 1, 0, 1, 0, 0));
      #1 rst = 1'b1;
      #1;
      chk("arst_d2", 0, g2(), pk(0, 0, 0, 0, 0, 0));
      chk("arst_d3", 0, g3(), pk(0, 0, 0, 0, 0, 0));
      chk("arst_d1", 0, g1(), pk(0, 0, 0, 0, 0, 0));
      tick();
      rst = 1'b0;
      tick();
      chk("post_arst_d2", 0, g2(), pk(0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_beat_gen.md
# cpu_beat_gen

Beat (timing-pulse) generator driven directly by the distributed CPU clock. It sequences the multicycle CPU through four one-hot beats T1–T4 per instruction, with a programmable beat length. It supports run, stop-at-instruction-boundary, single-step and halt control, and counts completed instructions. Its beat outputs feed the control unit and the datapath register enables.

## Interface
- DIV, 2, clock cycles per beat; legal range 1..256
- CNT_W, 16, width of the instruction counter
- clk  input  1  CPU clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  level sampled each edge; begins free-running execution
- stop  input  1  level sampled each edge; requests a stop at the next instruction boundary
- step  input  1  level sampled each edge; executes exactly one instruction from idle
- halt  input  1  level sampled each edge; stops immediately; only rst exits this state
- phase  output  4  one-hot beat, bit0=T1 … bit3=T4; 0000 when not executing
- beat_en  output  1  high for the first clk cycle of every beat
- instr_done  output  1  one-cycle pulse after T4 of each completed instruction
- running  output  1  high while in RUN or STEP
- halted  output  1  high while in HALTED
- instr_count  output  CNT_W  number of completed instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, RUN, STEP, HALTED. All outputs are registered.
- Prescaler `pre` counts 0..DIV-1 while in RUN or STEP. A tick occurs in the cycle where pre==DIV-1. The prescaler is cleared on entry to RUN or STEP.
- Control priority at each edge: halt > stop > start > step.
- IDLE:
  - start → RUN; step alone → STEP; start and step together → RUN.
  - On entry to RUN or STEP: phase=0001 and beat_en=1.
- RUN:
  - On each tick, phase rotates T1→T2→T3→T4→T1 and beat_en pulses.
  - start and step are ignored.
  - stop sets stop_pending; stop_pending is sticky until the boundary.
- Instruction boundary (tick while phase=T4):
  - instr_done=1 and instr_count increments.
  - If stop_pending, or the state is STEP: next state IDLE, phase=0000, stop_pending cleared, no beat_en.
  - Otherwise: phase=T1 and beat_en=1.
- STEP:
  - Same sequencing as RUN, but always returns to IDLE at the boundary.
  - stop, start and step are ignored.
- halt from any state:
  - Next state HALTED at the next edge; phase=0000; running=0; halted=1.
  - A partial instruction is abandoned: no instr_done, count unchanged.
  - pre and stop_pending are cleared.
- HALTED: all inputs except rst are ignored.
- stop in IDLE is ignored and does not set stop_pending.
- instr_count wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset values (asynchronous; outputs valid immediately on assertion):
  - state=IDLE, phase=0000, beat_en=0, instr_done=0, running=0, halted=0, instr_count=0, pre=0, stop_pending=0.
- Reset mid-instruction: the current beat is discarded; no instr_done pulse.
- Latency from start sampled high at edge k:
  - phase=0001, beat_en=1 and running=1 are visible after edge k.
  - T2 begins at edge k+DIV.
- Each beat lasts exactly DIV cycles; one instruction lasts 4·DIV cycles.
- beat_en is high only during the first cycle of each beat. With DIV=1 it is high every cycle of execution.
- instr_done is high in the cycle immediately after T4 ends. That cycle is the first cycle of the next T1, or the first cycle back in IDLE.
- instr_count updates at the same edge that raises instr_done.
- stop asserted during the final T4 cycle (the tick cycle) takes effect at that same boundary.
- halt has a 1-cycle latency and overrides a coincident instruction boundary: no instr_done, no count increment.

## Test plan
- Reset then idle:
  - Stimulus: DIV=2; assert rst for 3 cycles with all controls at 0; then wait 10 cycles.
  - Required: phase=0000 and instr_count=0 throughout; beat_en, running and halted stay 0.
- Free run:
  - Stimulus: DIV=2; pulse start for 1 cycle.
  - Required: phase sequence 0001,0001,0010,0010,0100,0100,1000,1000 repeating.
  - Required: beat_en high every 2nd cycle; instr_done every 8 cycles; instr_count=3 after 24 cycles.
- Stop at boundary:
  - Stimulus: DIV=3; run, then pulse stop during T2.
  - Required: T3 and T4 complete; then instr_done=1, phase=0000 and running=0.
  - Required: a second start resumes at T1 with instr_count preserved.
- Single step:
  - Stimulus: DIV=1; pulse step from IDLE.
  - Required: exactly 4 cycles 0001,0010,0100,1000; one instr_done; instr_count=1; back to IDLE.
  - Required: step held high re-steps every 5 cycles.
- Halt mid-instruction:
  - Stimulus: DIV=2; halt during T3.
  - Required: next cycle phase=0000, halted=1, no instr_done, count unchanged.
  - Required: start and step are ignored; only rst clears halted.
- Wrap and edge cases:
  - Stimulus: CNT_W=4, DIV=1; run 16 instructions.
  - Required: instr_count goes 15→0.
  - Stimulus: start+step together.
  - Required: RUN state.
  - Stimulus: assert rst during T2.
  - Required: all outputs are at their reset values asynchronously.
